dodgypla_seq: RTL and testbench



---
 rtl/dodgypla_seq.sv | 148 ++++++++++++++
 tb/tb_dodgypla_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dodgypla_seq.sv
// dodgypla_seq: clocked, runtime-programmable AND/OR product-term array.
// Raw inputs are synchronised, deglitched and then evaluated against the
// active term table. The table is loaded through a shadow bank and swapped
// in atomically on commit.
module dodgypla_seq #(
  parameter int N_IN       = 16,
  parameter int N_OUT      = 8,
  parameter int N_TERMS    = 48,
  parameter int STABLE_CNT = 2,
  parameter int AW         = $clog2(N_TERMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  i,
  output logic [N_OUT-1:0] f,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_field,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [N_IN-1:0]  cfg_wdata,
  input  logic             cfg_commit,
  output logic             cfg_err,
  output logic             in_stable
);

  // Counter only has to reach STABLE_CNT-1.
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

  // Input path registers
  logic [N_IN-1:0] r_s1, r_s2, r_cand, r_acc;
  logic [CW-1:0]   r_cnt;

  // Shadow and active tables
  logic [N_TERMS-1:0][N_IN-1:0]  r_sh_care, r_sh_val, r_ac_care, r_ac_val;
  logic [N_TERMS-1:0][N_OUT-1:0] r_sh_or, r_ac_or;
  logic [N_OUT-1:0]              r_sh_pol, r_ac_pol;
  logic [N_OUT-1:0]              r_f;
  logic                          r_err;

  // Next shadow state, also the source of a commit so a same-cycle write
  // lands in the active bank.
  logic [N_TERMS-1:0][N_IN-1:0]  w_care_nxt, w_val_nxt;
  logic [N_TERMS-1:0][N_OUT-1:0] w_or_nxt;
  logic [N_OUT-1:0]              w_pol_nxt;
  logic                          w_illegal;
  logic                          w_addr_ok;
  logic [N_TERMS-1:0]            w_match;
  logic [N_OUT-1:0]              w_or;

  assign w_addr_ok = ({1'b0, cfg_addr} < (AW+1)'(N_TERMS));
  assign in_stable = (r_s2 == r_acc);
  assign f         = r_f;
  assign cfg_err   = r_err;

  // Decode a config write into the next shadow bank; flag illegal targets.
  always_comb begin
    w_care_nxt = r_sh_care;
    w_val_nxt  = r_sh_val;
    w_or_nxt   = r_sh_or;
    w_pol_nxt  = r_sh_pol;
    w_illegal  = 1'b0;
    if (cfg_we) begin
      if (cfg_field == 2'd3) begin
        if (cfg_addr == '0) w_pol_nxt = cfg_wdata[N_OUT-1:0];
        else                w_illegal = 1'b1;
      end else if (!w_addr_ok) begin
        w_illegal = 1'b1;
      end else begin
        for (int t = 0; t < N_TERMS; t++) begin
          if (cfg_addr == AW'(t)) begin
            case (cfg_field)
              2'd0:    w_care_nxt[t] = cfg_wdata;
              2'd1:    w_val_nxt[t]  = cfg_wdata;
              default: w_or_nxt[t]   = cfg_wdata[N_OUT-1:0];
            endcase
          end
        end
      end
    end
  end

  // Synchroniser and stability filter feeding the accepted vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_cand <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i;
      r_s2 <= r_s1;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (r_cnt == CW'(STABLE_CNT-1)) begin
        r_acc <= r_cand;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Shadow bank update, atomic copy to active bank, error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_care <= '0;
      r_sh_val  <= '0;
      r_sh_or   <= '0;
      r_sh_pol  <= '0;
      r_ac_care <= '0;
      r_ac_val  <= '0;
      r_ac_or   <= '0;
      r_ac_pol  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_sh_care <= w_care_nxt;
      r_sh_val  <= w_val_nxt;
      r_sh_or   <= w_or_nxt;
      r_sh_pol  <= w_pol_nxt;
      r_err     <= w_illegal;
      if (cfg_commit) begin
        r_ac_care <= w_care_nxt;
        r_ac_val  <= w_val_nxt;
        r_ac_or   <= w_or_nxt;
        r_ac_pol  <= w_pol_nxt;
      end
    end
  end

  // Per-term match against the accepted vector using the active bank.
  for (genvar t = 0; t < N_TERMS; t++) begin : g_term
    assign w_match[t] = (((r_acc ^ r_ac_val[t]) & r_ac_care[t]) == '0);
  end

  // OR plane; a term with an empty OR mask contributes nothing.
  always_comb begin
    w_or = '0;
    for (int t = 0; t < N_TERMS; t++)
      if (w_match[t]) w_or = w_or | r_ac_or[t];
  end

  // Registered output with polarity.
  always_ff @(posedge clk) begin
    if (!rst_n) r_f <= '0;
    else        r_f <= r_ac_pol ^ w_or;
  end

endmodule

// File: tb/tb_dodgypla_seq.sv
// Directed self-checking bench for dodgypla_seq (default parameters).
module tb_dodgypla_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i;
  logic [7:0]  f;
  logic        cfg_we;
  logic [1:0]  cfg_field;
  logic [5:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_commit;
  logic        cfg_err;
  logic        in_stable;

  int n_tests = 0;
  int n_fail  = 0;

  dodgypla_seq dut (
    .clk(clk), .rst_n(rst_n), .i(i), .f(f),
    .cfg_we(cfg_we), .cfg_field(cfg_field), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_err(cfg_err), .in_stable(in_stable)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1ns after it.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] fld, input logic [5:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_field = fld; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i = 16'hFFFF; cfg_we = 1'b0; cfg_field = 2'd0;
    cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;

    // Reset state
    step(2);
    chk("rst_f", f, 8'h00);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_stable", in_stable, 1'b1);
    rst_n = 1'b1;

    // Idle with all-ones input: f stays 0, in_stable settles by E6
    step(2);
    chk("idle_unstable_e2", in_stable, 1'b0);
    chk("idle_f_e2", f, 8'h00);
    step(4);
    chk("idle_stable_e6", in_stable, 1'b1);
    chk("idle_f_e6", f, 8'h00);
    step();
    chk("idle_stable_e7", in_stable, 1'b1);
    chk("idle_err", cfg_err, 1'b0);

    // Term 0: bits[1:0]==01 -> out bit 0
    wr(2'd0, 6'd0, 16'h0003);
    wr(2'd1, 6'd0, 16'h0001);
    wr(2'd2, 6'd0, 16'h0001);
    wr(2'd3, 6'd0, 16'h0000);
    chk("prog_err", cfg_err, 1'b0);
    commit();
    i = 16'h0000;
    step(8);
    chk("base_0000", f, 8'h00);

    // 0000 -> 0001: f rises exactly at E6
    i = 16'h0001;
    step(5);
    chk("rise_e5", f, 8'h00);
    step();
    chk("rise_e6", f, 8'h01);
    // 0001 -> 0003: f falls exactly at E6
    i = 16'h0003;
    step(5);
    chk("fall_e5", f, 8'h01);
    step();
    chk("fall_e6", f, 8'h00);

    // Glitch filtering
    i = 16'h0000;
    step(8);
    i = 16'h0001;
    step(2);
    i = 16'h0000;
    step(8);
    chk("pulse2_ignored", f, 8'h00);
    i = 16'h0001;
    step(3);
    i = 16'h0000;
    step(2);
    chk("pulse3_e5", f, 8'h00);
    step();
    chk("pulse3_e6", f, 8'h01);
    step(2);
    chk("pulse3_e8", f, 8'h01);
    step();
    chk("pulse3_e9", f, 8'h00);

    // Shadow write without commit does not reach f
    i = 16'h0001;
    step(8);
    chk("match_base", f, 8'h01);
    wr(2'd2, 6'd0, 16'h0080);
    step(3);
    chk("shadow_only", f, 8'h01);
    // pol write with same-cycle commit (write-through)
    cfg_we = 1'b1; cfg_field = 2'd3; cfg_addr = 6'd0; cfg_wdata = 16'h00FF;
    cfg_commit = 1'b1;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    chk("commit_edge_old", f, 8'h01);
    step();
    chk("commit_new", f, 8'h7F);

    // Illegal write: term index out of range
    wr(2'd0, 6'd48, 16'hFFFF);
    chk("ill_addr_err", cfg_err, 1'b1);
    step();
    chk("ill_addr_err_clr", cfg_err, 1'b0);
    commit();
    step();
    chk("ill_addr_table", f, 8'h7F);
    // Illegal write: global register index
    wr(2'd3, 6'd1, 16'h0000);
    chk("ill_glob_err", cfg_err, 1'b1);
    step();
    chk("ill_glob_err_clr", cfg_err, 1'b0);
    commit();
    step();
    chk("ill_glob_table", f, 8'h7F);

    // Reset mid-filter with a same-cycle commit
    i = 16'h0003;
    step(2);
    rst_n = 1'b0; cfg_commit = 1'b1;
    step();
    rst_n = 1'b1; cfg_commit = 1'b0;
    chk("mid_rst_f", f, 8'h00);
    chk("mid_rst_err", cfg_err, 1'b0);
    chk("mid_rst_stable", in_stable, 1'b1);
    step(8);
    chk("mid_rst_active_clr", f, 8'h00);
    chk("mid_rst_settled", in_stable, 1'b1);
    commit();
    step();
    chk("mid_rst_shadow_clr", f, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
